// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types: MEM/WB wait-state encoding and write-back select codes
package pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    // Write-back select codes, shared by the decoder, pipe_mem_wb and multiplexor4 users
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

endpackage

// File: rtl/pipe_reg_en.sv
// rtl/pipe_reg_en.sv - pipeline field register with async reset, sync clear and load enable
// Ports:
//   clk  in          rising-edge clock
//   rst  in          asynchronous active-high reset, q -> 0
//   en   in          load d on the next edge
//   clr  in          synchronous clear, wins over en
//   d    in  WIDTH   next value
//   q    out WIDTH   registered value
module pipe_reg_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_mem_wb.sv
// rtl/pipe_mem_wb.sv - MEM/WB pipeline register with data-memory wait FSM and upstream stall
// Optional feature macro: PIPE_MEM_WB_PERF_EN (adds stallCount_o memory-wait counter)
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   valid_i, flush_i                    MEM-stage instruction valid / kill
//   memRead_i, memAck_i, memData_i      load request, read response strobe and word
//   aluResult_i, pcPlus4_i, immExt_i    remaining write-back candidates
//   resultSrc_i, regWrite_i, rd_i       write-back select, register write, destination
//   stall_o                             hold IF..MEM this cycle
//   datoA_o..datoD_o, selDato_o         registered candidates and select for multiplexor4
//   regWrite_o, rd_o, valid_o           registered write-back control
//   stallCount_o                        memory-wait cycles (PIPE_MEM_WB_PERF_EN only)
module pipe_mem_wb
    import pipe_pkg::*;
#(
    parameter int BITS     = 32,
    parameter int REG_BITS = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic                flush_i,
    input  logic                memRead_i,
    input  logic                memAck_i,
    input  logic [BITS-1:0]     memData_i,
    input  logic [BITS-1:0]     aluResult_i,
    input  logic [BITS-1:0]     pcPlus4_i,
    input  logic [BITS-1:0]     immExt_i,
    input  logic [1:0]          resultSrc_i,
    input  logic                regWrite_i,
    input  logic [REG_BITS-1:0] rd_i,
    output logic                stall_o,
    output logic [BITS-1:0]     datoA_o,
    output logic [BITS-1:0]     datoB_o,
    output logic [BITS-1:0]     datoC_o,
    output logic [BITS-1:0]     datoD_o,
    output logic [1:0]          selDato_o,
    output logic                regWrite_o,
    output logic [REG_BITS-1:0] rd_o,
    output logic                valid_o
`ifdef PIPE_MEM_WB_PERF_EN
    ,
    output logic [CNT_BITS-1:0] stallCount_o
`endif
);

    localparam int FW = 3 * BITS + 2 + REG_BITS;

    wb_state_t state, state_nxt;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a flush discards any pending read and returns to RUN
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN:      if (valid_i && memRead_i && !memAck_i) state_nxt = WAIT_MEM;
                WAIT_MEM: if (memAck_i) state_nxt = RUN;
                default:  state_nxt = RUN;
            endcase
        end
    end

    // Stall output: reset gates it so upstream never sees a stall while the core is held in reset
    always_comb begin
        stall_o = 1'b0;
        case (state)
            RUN:      stall_o = valid_i & memRead_i & ~memAck_i & ~flush_i;
            WAIT_MEM: stall_o = ~memAck_i & ~flush_i;
            default:  stall_o = 1'b0;
        endcase
        if (reset) begin
            stall_o = 1'b0;
        end
    end

    // Candidate words, select and destination: loaded whenever WB is not waiting on memory.
    // While stalled upstream holds these inputs, so holding here loses nothing.
    logic [FW-1:0] fields_q;

    pipe_reg_en #(.WIDTH(FW)) u_fields (
        .clk (clk),
        .rst (reset),
        .en  (~stall_o),
        .clr (1'b0),
        .d   ({aluResult_i, pcPlus4_i, immExt_i, resultSrc_i, rd_i}),
        .q   (fields_q)
    );

    assign {datoA_o, datoC_o, datoD_o, selDato_o, rd_o} = fields_q;

    // Memory word follows every read response, independent of state
    pipe_reg_en #(.WIDTH(BITS)) u_mem_data (
        .clk (clk),
        .rst (reset),
        .en  (memAck_i),
        .clr (1'b0),
        .d   (memData_i),
        .q   (datoB_o)
    );

    // Valid / register-write: a flush or a stall cycle inserts a bubble into WB
    pipe_reg_en #(.WIDTH(2)) u_ctrl (
        .clk (clk),
        .rst (reset),
        .en  (1'b1),
        .clr (flush_i | stall_o),
        .d   ({valid_i, regWrite_i & valid_i}),
        .q   ({valid_o, regWrite_o})
    );

`ifdef PIPE_MEM_WB_PERF_EN
    // Counts every cycle the pipeline is held for data memory, including the cycle the
    // missing load is first seen; saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCount_o <= '0;
        end else if (stall_o && (stallCount_o != {CNT_BITS{1'b1}})) begin
            stallCount_o <= stallCount_o + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end
    end
`else
    localparam int unused_cnt_bits = CNT_BITS;
`endif

endmodule
